// File: rtl/compid_field_emitter.sv
`default_nettype none
// ============================================================================
//  Module   : compid_field_emitter
//  Purpose  : Serializes one host CompID table entry as a FIX field
//             "49=<id><SOH>" (SenderCompID) or "56=<id><SOH>" (TargetCompID)
//             onto a valid/ready byte stream.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        : clock, all logic on rising edge
//    rst        : synchronous active-high reset
//    start      : request to emit one field (sampled only in IDLE)
//    entry      : [79:0] value (byte 0 in [7:0]), [89:80] byte-valid mask,
//                 [90] role (1 = initiator, 0 = acceptor)
//    host_size  : CompID length in bytes
//    sel_target : 1 = tag 56, 0 = tag 49
//    out_data   : current byte
//    out_valid  : out_data is valid
//    out_ready  : downstream accepts the byte
//    out_last   : marks the SOH byte (qualified by out_valid)
//    busy       : high whenever a field is being emitted
//    done       : one-cycle pulse after the SOH byte is accepted
//    err        : one-cycle pulse when a start is rejected
//    role       : entry role bit captured on the last accepted start
// ============================================================================
module compid_field_emitter #(
   parameter int VALUE_DATA_WIDTH = 80,
   parameter int VALUE_SIZE       = 10,
   parameter int DATA_WIDTH       = VALUE_DATA_WIDTH + VALUE_SIZE + 1,
   parameter int SIZE             = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] entry,
   input  logic [SIZE-1:0]       host_size,
   input  logic                  sel_target,
   output logic [7:0]            out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic                  role
);

   localparam int IDX_W    = (VALUE_SIZE > 1) ? $clog2(VALUE_SIZE) : 1;
   localparam int MASK_LSB = VALUE_DATA_WIDTH;
   localparam int ROLE_BIT = VALUE_DATA_WIDTH + VALUE_SIZE;

   localparam logic [7:0] ASCII_4  = 8'h34;
   localparam logic [7:0] ASCII_5  = 8'h35;
   localparam logic [7:0] ASCII_6  = 8'h36;
   localparam logic [7:0] ASCII_9  = 8'h39;
   localparam logic [7:0] ASCII_EQ = 8'h3D;
   localparam logic [7:0] SOH_BYTE = 8'h01;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      TAG0 = 3'd1,
      TAG1 = 3'd2,
      EQ   = 3'd3,
      VAL  = 3'd4,
      SOH  = 3'd5
   } state_t;

   state_t                      state;
   logic [IDX_W-1:0]            idx;
   logic [VALUE_DATA_WIDTH-1:0] value_r;
   logic [SIZE-1:0]             size_r;
   logic                        sel_r;

   logic [7:0]                  value_bytes [VALUE_SIZE];
   logic [IDX_W-1:0]            next_idx;
   logic                        last_val;
   logic                        start_bad;

   // Byte view of the latched value; byte 0 sits in the low bits.
   genvar b;
   generate
      for (b = 0; b < VALUE_SIZE; b++) begin : g_bytes
         assign value_bytes[b] = value_r[8*b +: 8];
      end
   endgenerate

   assign next_idx = idx + IDX_W'(1);
   assign last_val = (SIZE'(idx) == (size_r - SIZE'(1)));
   assign busy     = (state != IDLE);

   // A start is rejected if the length is out of range or any byte inside
   // the requested length is not marked valid. Mask bits past the length
   // are ignored.
   always_comb begin
      start_bad = (host_size == '0) || (host_size > SIZE'(VALUE_SIZE));
      for (int i = 0; i < VALUE_SIZE; i++) begin
         if ((SIZE'(i) < host_size) && !entry[MASK_LSB + i]) begin
            start_bad = 1'b1;
         end
      end
   end

   // Each state holds the byte currently on the bus; a state only advances
   // when that byte is accepted, so out_* stay stable under backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         value_r   <= '0;
         size_r    <= '0;
         sel_r     <= 1'b0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         role      <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  value_r <= entry[VALUE_DATA_WIDTH-1:0];
                  size_r  <= host_size;
                  sel_r   <= sel_target;
                  role    <= entry[ROLE_BIT];
                  if (start_bad) begin
                     err <= 1'b1;
                  end else begin
                     state     <= TAG0;
                     out_valid <= 1'b1;
                     out_data  <= sel_target ? ASCII_5 : ASCII_4;
                  end
               end
            end
            TAG0: begin
               if (out_ready) begin
                  state    <= TAG1;
                  out_data <= sel_r ? ASCII_6 : ASCII_9;
               end
            end
            TAG1: begin
               if (out_ready) begin
                  state    <= EQ;
                  out_data <= ASCII_EQ;
               end
            end
            EQ: begin
               if (out_ready) begin
                  state    <= VAL;
                  idx      <= '0;
                  out_data <= value_bytes[0];
               end
            end
            VAL: begin
               if (out_ready) begin
                  if (last_val) begin
                     state    <= SOH;
                     out_data <= SOH_BYTE;
                     out_last <= 1'b1;
                  end else begin
                     idx      <= next_idx;
                     out_data <= value_bytes[next_idx];
                  end
               end
            end
            SOH: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
                  out_data  <= '0;
                  done      <= 1'b1;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               out_last  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_compid_field_emitter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_compid_field_emitter
//  Purpose  : Directed self-checking bench for compid_field_emitter.
//             Inputs change and outputs are sampled on the falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_compid_field_emitter;

   localparam logic [90:0] FULL_ENTRY  = {1'b0, 10'h3FF, 80'h686374616d726564726f};
   localparam logic [90:0] SHORT_ENTRY = {1'b1, 10'h01F, 80'h484354414d524544524f};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [90:0] entry = '0;
   logic [5:0]  host_size = '0;
   logic        sel_target = 1'b0;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        out_last;
   logic        busy;
   logic        done;
   logic        err;
   logic        role;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [7:0] exp_full  [14];
   logic [7:0] exp_short [9];

   compid_field_emitter dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .entry      (entry),
      .host_size  (host_size),
      .sel_target (sel_target),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .role       (role)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Drive a one-cycle start from a falling edge; returns on the falling
   // edge where the first byte (if accepted) is visible.
   task automatic start_field(input logic [90:0] e, input logic [5:0] sz, input logic sel);
      entry      = e;
      host_size  = sz;
      sel_target = sel;
      start      = 1'b1;
      @(negedge clk);
      start      = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total_cnt++;
      if ({out_valid, out_last, busy, done, err, role} !== 6'b0)
         $display("FAIL reset_flags: got %b want 000000", {out_valid, out_last, busy, done, err, role});
      else pass_cnt++;
      total_cnt++;
      if (out_data !== 8'h00) $display("FAIL reset_data: got %h want 00", out_data);
      else pass_cnt++;
      rst = 1'b0;
      @(negedge clk);
      total_cnt++;
      if ({out_valid, busy} !== 2'b00) $display("FAIL post_reset_idle: got %b want 00", {out_valid, busy});
      else pass_cnt++;
   endtask

   task automatic test_full();
      out_ready = 1'b1;
      start_field(FULL_ENTRY, 6'd10, 1'b1);
      for (int i = 0; i < 14; i++) begin
         total_cnt++;
         if ({out_valid, busy, out_last, done, out_data} !== {1'b1, 1'b1, (i == 13), 1'b0, exp_full[i]})
            $display("FAIL full_beat%0d: got %b want %b", i, {out_valid, busy, out_last, done, out_data},
                     {1'b1, 1'b1, (i == 13), 1'b0, exp_full[i]});
         else pass_cnt++;
         @(negedge clk);
      end
      total_cnt++;
      if ({done, out_valid, busy, role} !== 4'b1000)
         $display("FAIL full_done: got %b want 1000", {done, out_valid, busy, role});
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if (done !== 1'b0) $display("FAIL full_done_pulse: got %b want 0", done);
      else pass_cnt++;
   endtask

   task automatic test_short();
      out_ready = 1'b1;
      start_field(SHORT_ENTRY, 6'd5, 1'b0);
      for (int i = 0; i < 9; i++) begin
         total_cnt++;
         if ({out_valid, out_last, done, out_data} !== {1'b1, (i == 8), 1'b0, exp_short[i]})
            $display("FAIL short_beat%0d: got %b want %b", i, {out_valid, out_last, done, out_data},
                     {1'b1, (i == 8), 1'b0, exp_short[i]});
         else pass_cnt++;
         @(negedge clk);
      end
      total_cnt++;
      if ({done, out_valid, busy, role} !== 4'b1001)
         $display("FAIL short_done: got %b want 1001", {done, out_valid, busy, role});
      else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int cnt = 0;
      int cyc = 0;
      bit seen_done = 1'b0;
      start_field(FULL_ENTRY, 6'd10, 1'b1);
      while (!seen_done && cyc < 100) begin
         out_ready = ((cyc % 3) == 0);
         if (done) begin
            seen_done = 1'b1;
         end else if (out_valid) begin
            total_cnt++;
            if (cnt >= 14) begin
               $display("FAIL bp_extra_byte: got %h want no byte", out_data);
            end else if ({out_last, out_data} !== {(cnt == 13), exp_full[cnt]}) begin
               $display("FAIL bp_byte%0d: got %b want %b", cnt, {out_last, out_data}, {(cnt == 13), exp_full[cnt]});
            end else pass_cnt++;
            if (out_ready) cnt++;
         end
         cyc++;
         @(negedge clk);
      end
      out_ready = 1'b1;
      total_cnt++;
      if (!seen_done) $display("FAIL bp_done_timeout: got no done want done");
      else pass_cnt++;
      total_cnt++;
      if (cnt != 14) $display("FAIL bp_count: got %0d want 14", cnt);
      else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_rejects();
      logic [5:0] sizes [3];
      logic [9:0] masks [3];
      sizes[0] = 6'd0;  masks[0] = 10'h3FF;
      sizes[1] = 6'd11; masks[1] = 10'h3FF;
      sizes[2] = 6'd5;  masks[2] = 10'h3EF;
      for (int k = 0; k < 3; k++) begin
         start_field({1'b1, masks[k], FULL_ENTRY[79:0]}, sizes[k], 1'b0);
         total_cnt++;
         if ({err, out_valid, busy} !== 3'b100)
            $display("FAIL reject%0d_err: got %b want 100", k, {err, out_valid, busy});
         else pass_cnt++;
         @(negedge clk);
         total_cnt++;
         if ({err, out_valid, busy} !== 3'b000)
            $display("FAIL reject%0d_after: got %b want 000", k, {err, out_valid, busy});
         else pass_cnt++;
      end
      total_cnt++;
      if (role !== 1'b1) $display("FAIL reject_role: got %b want 1", role);
      else pass_cnt++;
   endtask

   task automatic test_busy_reset();
      out_ready = 1'b1;
      start_field(FULL_ENTRY, 6'd10, 1'b1);
      for (int i = 0; i < 6; i++) begin
         total_cnt++;
         if ({out_valid, err, out_data} !== {1'b1, 1'b0, exp_full[i]})
            $display("FAIL busy_beat%0d: got %b want %b", i, {out_valid, err, out_data}, {1'b1, 1'b0, exp_full[i]});
         else pass_cnt++;
         if (i == 2) begin
            entry = SHORT_ENTRY; host_size = 6'd5; sel_target = 1'b0; start = 1'b1;
         end
         if (i == 3) start = 1'b0;
         if (i == 5) rst = 1'b1;
         @(negedge clk);
      end
      total_cnt++;
      if ({out_valid, busy, done, out_last} !== 4'b0000)
         $display("FAIL mid_reset: got %b want 0000", {out_valid, busy, done, out_last});
      else pass_cnt++;
      rst = 1'b0;
      @(negedge clk);
      total_cnt++;
      if ({done, out_valid} !== 2'b00) $display("FAIL mid_reset_nodone: got %b want 00", {done, out_valid});
      else pass_cnt++;
      start_field(SHORT_ENTRY, 6'd5, 1'b0);
      for (int i = 0; i < 9; i++) begin
         total_cnt++;
         if ({out_valid, out_last, out_data} !== {1'b1, (i == 8), exp_short[i]})
            $display("FAIL restart_beat%0d: got %b want %b", i, {out_valid, out_last, out_data}, {1'b1, (i == 8), exp_short[i]});
         else pass_cnt++;
         @(negedge clk);
      end
      total_cnt++;
      if (done !== 1'b1) $display("FAIL restart_done: got %b want 1", done);
      else pass_cnt++;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      start_field(SHORT_ENTRY, 6'd5, 1'b0);
      repeat (9) @(negedge clk);
      total_cnt++;
      if ({done, out_valid} !== 2'b10) $display("FAIL b2b_first_done: got %b want 10", {done, out_valid});
      else pass_cnt++;
      start_field(FULL_ENTRY, 6'd10, 1'b1);
      total_cnt++;
      if ({out_valid, done, out_data} !== {1'b1, 1'b0, 8'h35})
         $display("FAIL b2b_first_tag: got %b want %b", {out_valid, done, out_data}, {1'b1, 1'b0, 8'h35});
      else pass_cnt++;
      @(negedge clk);
      for (int i = 1; i < 14; i++) begin
         total_cnt++;
         if ({out_valid, out_last, out_data} !== {1'b1, (i == 13), exp_full[i]})
            $display("FAIL b2b_beat%0d: got %b want %b", i, {out_valid, out_last, out_data}, {1'b1, (i == 13), exp_full[i]});
         else pass_cnt++;
         @(negedge clk);
      end
      total_cnt++;
      if ({done, role} !== 2'b10) $display("FAIL b2b_done: got %b want 10", {done, role});
      else pass_cnt++;
      @(negedge clk);
   endtask

   initial begin
      exp_full  = '{8'h35, 8'h36, 8'h3D, 8'h6F, 8'h72, 8'h64, 8'h65,
                    8'h72, 8'h6D, 8'h61, 8'h74, 8'h63, 8'h68, 8'h01};
      exp_short = '{8'h34, 8'h39, 8'h3D, 8'h4F, 8'h52, 8'h44, 8'h45, 8'h52, 8'h01};
      test_reset();
      test_full();
      test_short();
      test_backpressure();
      test_rejects();
      test_busy_reset();
      test_back_to_back();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/compid_field_emitter.md
Name: compid_field_emitter

Overview:
- Transmit-side counterpart of the host CompID table: takes one host table entry (80-bit ASCII CompID value, 10-bit byte-valid mask, initiator/acceptor bit) plus its 6-bit size, and serializes it as a FIX field "49=<id><SOH>" or "56=<id><SOH>".
- Output is a byte stream with valid/ready handshake, feeding the outbound message assembler.
- Value byte 0 is in bits [7:0] of the value, LSB-first, matching the table layout. Example: value 80'h6f726465726d61746368 is sent as "hctamredro"; value 80'h686374616d726564726f is sent as "ordermatch".

Parameters:
- VALUE_DATA_WIDTH, `VALUE_DATA_WIDTH (80): CompID value width in bits; must be a multiple of 8.
- VALUE_SIZE, `VALUE_SIZE (10): maximum CompID length in bytes; equals the mask width.
- DATA_WIDTH, VALUE_DATA_WIDTH+VALUE_SIZE+1 (91): table entry width.
- SIZE, 6: width of the length field.

Ports:
- clk, input, 1: clock; all logic on posedge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: request to emit one field; sampled only in IDLE.
- entry, input, DATA_WIDTH: [79:0] value, [89:80] byte-valid mask, [90] role; sampled on accepted start.
- host_size, input, SIZE: CompID length in bytes; sampled on accepted start.
- sel_target, input, 1: 1 = tag 56 (TargetCompID), 0 = tag 49 (SenderCompID); sampled on accepted start.
- out_data, output, 8: current byte.
- out_valid, output, 1: out_data is valid.
- out_ready, input, 1: downstream accepts the byte.
- out_last, output, 1: marks the SOH byte; qualified by out_valid.
- busy, output, 1: high whenever state is not IDLE.
- done, output, 1: one-cycle pulse after the last byte is accepted.
- err, output, 1: one-cycle pulse when a start is rejected.
- role, output, 1: entry[90] captured on the last accepted start (1 = initiator, 0 = acceptor).

Behaviour:
- Reset values: out_valid=0, out_data=0, out_last=0, busy=0, done=0, err=0, role=0, state=IDLE, byte counter=0. Reset overrides everything; reset mid-emission aborts with no done, and the next start after reset begins a fresh field.
- States: IDLE, TAG0, TAG1, EQ, VAL, SOH.
- Accepted start = start & IDLE. On an accepted start, latch entry, host_size, sel_target and role, then validate:
  - host_size==0, or host_size>VALUE_SIZE, or any mask bit i (i<host_size) ==0 -> err=1 next cycle, remain IDLE, out_valid stays 0.
  - Otherwise -> TAG0, with out_valid=1 and out_data='4'(0x34) or '5'(0x35) in the next cycle. Latency is 1 cycle from start to first valid byte.
- start while busy is ignored; no err, no effect on the field in progress.
- Beat advance happens only on out_valid & out_ready. Until then out_data, out_last and out_valid are held stable.
- Byte sequence per state:
  - TAG0: 0x34 or 0x35, then TAG1.
  - TAG1: 0x39 or 0x36, then EQ.
  - EQ: 0x3D, then VAL with idx=0.
  - VAL: value[8*idx+7:8*idx]; idx increments per beat; at idx==host_size-1 go to SOH.
  - SOH: 0x01 with out_last=1.
- Back-to-back beats are allowed: with out_ready held high, one byte per cycle, so a field takes host_size+4 cycles.
- SOH accepted -> IDLE with out_valid=0; done=1 during the first IDLE cycle. A start in that same cycle is accepted, so there is no dead cycle beyond the done cycle.
- Mask bits at or above host_size are don't-care. Value bytes beyond host_size are never emitted.
- idx is ceil(log2(VALUE_SIZE)) bits and never wraps, because host_size<=VALUE_SIZE is enforced.

Test Plan:
- Full-length field: entry value=80'h686374616d726564726f, mask=10'h3FF, role=0, host_size=10, sel_target=1, out_ready=1. Expect 14 consecutive beats 35 36 3D 6F 72 64 65 72 6D 61 74 63 68 01; out_last only on 01; done 1 cycle after 01; role=0.
- Short field: value=80'h484354414d524544524f, mask=10'h01F, host_size=5, sel_target=0. Expect 34 39 3D 4F 52 44 45 52 01 (ORDER); role=1.
- Backpressure: as the full-length field, with out_ready toggling 1,0,0,1,... Each byte is held stable while ready=0; no byte is lost or duplicated; the total byte count is 14.
- Rejects: host_size=0 -> err pulse, no valid. host_size=11 -> err. host_size=5 with mask=10'h3EF -> err. After each reject, busy stays 0.
- Start during busy, then reset: pulse start again mid-field -> byte stream unaffected. Assert rst at the 6th beat -> next cycle out_valid=0, busy=0, no done. A new start then produces a correct, complete field.
- Back-to-back: assert start in the done cycle -> the second field's first tag byte is valid the following cycle.
